alpharetz_spi_master_v2: RTL and testbench

//   Parametrised full-duplex SPI controller; next generation of the Alpharetz SPI controller.

---
 rtl/alpharetz_spi_master_v2_if.sv | 34 +++
 rtl/alpharetz_spi_master_v2.sv | 184 ++++++++++++++++++
 tb/tb_alpharetz_spi_master_v2.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alpharetz_spi_master_v2_if.sv
// Request/response bus plus SPI pins for the Alpharetz SPI controller.
// The master modport is the CPU/peripheral side. The slave modport is the controller.
interface alpharetz_spi_master_v2_if #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter int PERI_CNT       = 4,
    parameter int P_ADDR_WIDTH   = 2,
    parameter int DIV_WIDTH      = 8
);
    logic [SPI_DATA_WIDTH-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [P_ADDR_WIDTH-1:0]   p_addr;
    logic                      cpol;
    logic                      cpha;
    logic                      lsb_first;
    logic [DIV_WIDTH-1:0]      clk_div;
    logic                      cipo;
    logic                      copi;
    logic                      p_clk;
    logic [PERI_CNT-1:0]       p_sel_n;
    logic [SPI_DATA_WIDTH-1:0] rx_data;
    logic                      rx_valid;
    logic                      busy;

    modport master (
        output tx_data, tx_valid, p_addr, cpol, cpha, lsb_first, clk_div, cipo,
        input  tx_ready, copi, p_clk, p_sel_n, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid, p_addr, cpol, cpha, lsb_first, clk_div, cipo,
        output tx_ready, copi, p_clk, p_sel_n, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/alpharetz_spi_master_v2.sv
// Full-duplex SPI controller with runtime CPOL/CPHA, clock divider and bit order.
// One word per request; select asserted at accept and released for one cycle after DONE.
module alpharetz_spi_master_v2 #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter int PERI_CNT       = 4,
    parameter int P_ADDR_WIDTH   = 2,
    parameter int DIV_WIDTH      = 8
) (
    input logic                      sys_clk,
    input logic                      sync_rst_n,
    input logic                      sys_clk_en,
    alpharetz_spi_master_v2_if.slave bus
);
    localparam int CNT_W = $clog2(SPI_DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * SPI_DATA_WIDTH - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_HOLD, ST_DONE} state_t;

    state_t                    state_q, state_d;
    logic [DIV_WIDTH-1:0]      div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0]      div_lim_q, div_lim_d;
    logic [CNT_W-1:0]          edge_cnt_q, edge_cnt_d;
    logic [SPI_DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                      cpha_q, cpha_d;
    logic                      cpol_q, cpol_d;
    logic                      lsb_q, lsb_d;
    logic                      p_clk_q, p_clk_d;
    logic                      copi_q, copi_d;
    logic [PERI_CNT-1:0]       sel_n_q, sel_n_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      busy_q, busy_d;
    logic [PERI_CNT-1:0]       sel_dec;
    logic                      tick;
    logic                      sample_edge;

    // Out-of-range addresses decode to no select at all.
    always_comb begin
        sel_dec = '1;
        for (int i = 0; i < PERI_CNT; i++) begin
            sel_dec[i] = (bus.p_addr != P_ADDR_WIDTH'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        div_lim_d   = div_lim_q;
        edge_cnt_d  = edge_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        cpha_d      = cpha_q;
        cpol_d      = cpol_q;
        lsb_d       = lsb_q;
        p_clk_d     = p_clk_q;
        copi_d      = copi_q;
        sel_n_d     = sel_n_q;
        rx_valid_d  = 1'b0;
        busy_d      = busy_q;
        tick        = (div_cnt_q == div_lim_q);
        sample_edge = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                p_clk_d = bus.cpol;
                sel_n_d = '1;
                busy_d  = 1'b0;
                if (bus.tx_valid) begin
                    state_d    = ST_SETUP;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    div_lim_d  = bus.clk_div;
                    cpol_d     = bus.cpol;
                    cpha_d     = bus.cpha;
                    lsb_d      = bus.lsb_first;
                    sel_n_d    = sel_dec;
                    busy_d     = 1'b1;
                    rx_shift_d = '0;
                    // With cpha=0 the first bit must be on the wire before the leading edge.
                    if (!bus.cpha) begin
                        copi_d     = bus.lsb_first ? bus.tx_data[0] : bus.tx_data[SPI_DATA_WIDTH-1];
                        tx_shift_d = bus.lsb_first ? (bus.tx_data >> 1) : (bus.tx_data << 1);
                    end else begin
                        copi_d     = 1'b0;
                        tx_shift_d = bus.tx_data;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    div_cnt_d = '0;
                    state_d   = ST_XFER;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    div_cnt_d   = '0;
                    p_clk_d     = ~p_clk_q;
                    edge_cnt_d  = edge_cnt_q + 1'b1;
                    // Even edge indices are leading edges; cpha flips which one samples.
                    sample_edge = (~edge_cnt_q[0]) ^ cpha_q;
                    if (sample_edge) begin
                        rx_shift_d = lsb_q ? {bus.cipo, rx_shift_q[SPI_DATA_WIDTH-1:1]}
                                           : {rx_shift_q[SPI_DATA_WIDTH-2:0], bus.cipo};
                    end else if (edge_cnt_q != LAST_EDGE) begin
                        copi_d     = lsb_q ? tx_shift_q[0] : tx_shift_q[SPI_DATA_WIDTH-1];
                        tx_shift_d = lsb_q ? (tx_shift_q >> 1) : (tx_shift_q << 1);
                    end
                    if (edge_cnt_q == LAST_EDGE) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    div_cnt_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                sel_n_d    = '1;
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                copi_d     = 1'b0;
                busy_d     = 1'b0;
                p_clk_d    = cpol_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            div_lim_q  <= '0;
            edge_cnt_q <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            cpha_q     <= 1'b0;
            cpol_q     <= 1'b0;
            lsb_q      <= 1'b0;
            p_clk_q    <= 1'b0;
            copi_q     <= 1'b0;
            sel_n_q    <= '1;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (sys_clk_en) begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_lim_q  <= div_lim_d;
            edge_cnt_q <= edge_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            cpha_q     <= cpha_d;
            cpol_q     <= cpol_d;
            lsb_q      <= lsb_d;
            p_clk_q    <= p_clk_d;
            copi_q     <= copi_d;
            sel_n_q    <= sel_n_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.tx_ready = (state_q == ST_IDLE);
    assign bus.copi     = copi_q;
    assign bus.p_clk    = p_clk_q;
    assign bus.p_sel_n  = sel_n_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_alpharetz_spi_master_v2.sv
// Self-checking bench for alpharetz_spi_master_v2 against an event-driven SPI peripheral model.
// Expected latency, edge count and half-period come from plain arithmetic on the configuration.
module tb_alpharetz_spi_master_v2;
    localparam int W  = 8;
    localparam int PC = 4;
    localparam int AW = 2;
    localparam int DW = 8;

    logic sys_clk = 1'b0;
    logic sync_rst_n;
    logic sys_clk_en;

    int vectors     = 0;
    int miscompares = 0;

    alpharetz_spi_master_v2_if #(.SPI_DATA_WIDTH(W), .PERI_CNT(PC), .P_ADDR_WIDTH(AW), .DIV_WIDTH(DW)) bus ();

    alpharetz_spi_master_v2 #(.SPI_DATA_WIDTH(W), .PERI_CNT(PC), .P_ADDR_WIDTH(AW), .DIV_WIDTH(DW)) dut (
        .sys_clk    (sys_clk),
        .sync_rst_n (sync_rst_n),
        .sys_clk_en (sys_clk_en),
        .bus        (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Peripheral model: shifts its response out and collects copi on the mode's edges.
    logic          loopback = 1'b0;
    logic          slv_cipo = 1'b0;
    logic          slv_active = 1'b0;
    logic          slv_cpol = 1'b0, slv_cpha = 1'b0, slv_lsb = 1'b0;
    logic [W-1:0]  slv_resp = '0, slv_rcv = '0;
    int            slv_idx = 0, edge_cnt = 0, en_cycles = 0, stamp1 = 0, stamp2 = 0;

    assign bus.cipo = loopback ? bus.copi : slv_cipo;

    function automatic int bitpos(input int k);
        return slv_lsb ? k : (W - 1 - k);
    endfunction

    always @(posedge sys_clk) if (sys_clk_en) en_cycles++;

    always @(bus.p_clk) begin
        if (slv_active) begin
            edge_cnt++;
            if (edge_cnt == 1) stamp1 = en_cycles;
            if (edge_cnt == 2) stamp2 = en_cycles;
            if ((bus.p_clk != slv_cpol) ^ slv_cpha) begin
                if (slv_idx < W) slv_rcv[bitpos(slv_idx)] = bus.copi;
                slv_idx++;
            end else if (slv_idx < W) begin
                slv_cipo = slv_resp[bitpos(slv_idx)];
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    logic [W-1:0]  cur_data, cur_resp;
    logic [DW-1:0] cur_div;

    // Configure, let p_clk settle to cpol in IDLE, then issue one accepted request.
    task automatic apply_stimulus(input logic cpol, input logic cpha, input logic lsb,
                                  input logic [DW-1:0] div, input logic [AW-1:0] addr,
                                  input logic [W-1:0] data, input logic [W-1:0] resp, input logic lb);
        @(negedge sys_clk);
        sys_clk_en    = 1'b1;
        bus.tx_valid  = 1'b0;
        bus.cpol      = cpol;
        bus.cpha      = cpha;
        bus.lsb_first = lsb;
        bus.clk_div   = div;
        bus.p_addr    = addr;
        bus.tx_data   = data;
        loopback      = lb;
        slv_cpol      = cpol;
        slv_cpha      = cpha;
        slv_lsb       = lsb;
        slv_resp      = resp;
        cur_data      = data;
        cur_resp      = resp;
        cur_div       = div;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_output("p_clk_idle", bus.p_clk, cpol);
        slv_idx    = 0;
        slv_rcv    = '0;
        edge_cnt   = 0;
        slv_cipo   = cpha ? 1'b0 : resp[bitpos(0)];
        slv_active = 1'b1;
        bus.tx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        check_output("accept_busy", bus.busy, 1'b1);
        @(negedge sys_clk);
        bus.tx_valid  = 1'b0;
        bus.tx_data   = W'($urandom);
        bus.cpha      = 1'($urandom);
        bus.lsb_first = 1'($urandom);
        bus.clk_div   = DW'($urandom);
        bus.p_addr    = AW'($urandom);
    endtask

    // Waits for rx_valid counting enabled cycles, then checks everything against the model.
    task automatic check_output_xfer(input string tag, input bit rand_en);
        int lat;
        bit timed_out;
        int h;
        lat = 0;
        timed_out = 1'b1;
        h = int'(cur_div) + 1;
        for (int c = 0; c < 20000; c++) begin
            sys_clk_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge sys_clk);
            if (sys_clk_en) lat++;
            #1;
            if (bus.rx_valid) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge sys_clk);
        end
        slv_active = 1'b0;
        check_output({tag, "_timeout"}, timed_out, 1'b0);
        check_output({tag, "_latency"}, lat, (2 * W + 2) * h + 1);
        check_output({tag, "_rx_data"}, bus.rx_data, loopback ? cur_data : cur_resp);
        check_output({tag, "_periph_rx"}, slv_rcv, cur_data);
        check_output({tag, "_edges"}, edge_cnt, 2 * W);
        check_output({tag, "_half_period"}, stamp2 - stamp1, h);
        check_output({tag, "_p_clk_end"}, bus.p_clk, slv_cpol);
        check_output({tag, "_sel_released"}, bus.p_sel_n, {PC{1'b1}});
        check_output({tag, "_busy_low"}, bus.busy, 1'b0);
        @(negedge sys_clk);
        sys_clk_en = 1'b1;
    endtask

    initial begin
        logic [PC-1:0] sel_a, sel_b;
        logic [W-1:0]  rx1, rx2;
        int            rxv, gap_busy, gap_sel;
        bit            sel_a_set, sel_b_set, reached, saw_rxv;

        sync_rst_n    = 1'b0;
        sys_clk_en    = 1'b1;
        bus.tx_data   = '0;
        bus.tx_valid  = 1'b0;
        bus.p_addr    = '0;
        bus.cpol      = 1'b0;
        bus.cpha      = 1'b0;
        bus.lsb_first = 1'b0;
        bus.clk_div   = '0;
        #12;
        check_output("rst_tx_ready", bus.tx_ready, 1'b1);
        check_output("rst_busy", bus.busy, 1'b0);
        check_output("rst_rx_valid", bus.rx_valid, 1'b0);
        check_output("rst_rx_data", bus.rx_data, '0);
        check_output("rst_copi", bus.copi, 1'b0);
        check_output("rst_p_clk", bus.p_clk, 1'b0);
        check_output("rst_p_sel_n", bus.p_sel_n, {PC{1'b1}});
        @(negedge sys_clk);
        sync_rst_n = 1'b1;

        $display("[TB] mode 0 loopback, 0xA5");
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'hA5, 8'h00, 1'b1);
        check_output_xfer("mode0", 1'b0);

        $display("[TB] modes 1..3 with peripheral model");
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'd1, 2'd1, 8'h3C, 8'hC3, 1'b0);
        check_output_xfer("mode1", 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'd1, 2'd2, 8'h3C, 8'hC3, 1'b0);
        check_output_xfer("mode2", 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'd1, 2'd3, 8'h3C, 8'hC3, 1'b0);
        check_output_xfer("mode3", 1'b0);

        $display("[TB] lsb first");
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd1, 2'd0, 8'h01, 8'h00, 1'b1);
        check_output_xfer("lsb_first", 1'b0);

        $display("[TB] back-to-back requests");
        @(negedge sys_clk);
        sys_clk_en = 1'b1; loopback = 1'b1;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.clk_div = '0;
        bus.p_addr = 2'd2; bus.tx_data = 8'h5A; bus.tx_valid = 1'b1;
        rxv = 0; gap_busy = 0; gap_sel = 0; sel_a = '1; sel_b = '1; rx1 = '0; rx2 = '0;
        sel_a_set = 1'b0; sel_b_set = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge sys_clk);
            #1;
            if (bus.rx_valid) begin
                rxv++;
                if (rxv == 1) rx1 = bus.rx_data;
                else rx2 = bus.rx_data;
            end
            if (rxv >= 2) break;
            if (rxv == 0 && bus.p_sel_n != {PC{1'b1}} && !sel_a_set) begin
                sel_a = bus.p_sel_n; sel_a_set = 1'b1;
            end
            if (rxv == 1) begin
                if (!bus.busy) gap_busy++;
                if (bus.p_sel_n == {PC{1'b1}}) gap_sel++;
                else if (!sel_b_set) begin sel_b = bus.p_sel_n; sel_b_set = 1'b1; end
            end
            @(negedge sys_clk);
            if (rxv == 0 && bus.busy) begin bus.p_addr = 2'd0; bus.tx_data = 8'h96; end
            if (rxv == 1 && bus.busy) bus.tx_valid = 1'b0;
        end
        check_output("b2b_count", rxv, 2);
        check_output("b2b_sel_first", sel_a, 4'b1011);
        check_output("b2b_sel_second", sel_b, 4'b1110);
        check_output("b2b_busy_gap", gap_busy, 1);
        check_output("b2b_sel_gap", gap_sel, 1);
        check_output("b2b_rx1", rx1, 8'h5A);
        check_output("b2b_rx2", rx2, 8'h96);
        bus.tx_valid = 1'b0;
        for (int c = 0; c < 100 && bus.busy; c++) @(negedge sys_clk);

        $display("[TB] reset mid-transfer");
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 8'h5A, 8'h00, 1'b1);
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (edge_cnt >= 8) begin reached = 1'b1; break; end
            @(negedge sys_clk);
        end
        check_output("abort_reached_bit4", reached, 1'b1);
        slv_active = 1'b0;
        sync_rst_n = 1'b0;
        #1;
        check_output("abort_p_sel_n", bus.p_sel_n, {PC{1'b1}});
        check_output("abort_p_clk", bus.p_clk, 1'b0);
        check_output("abort_busy", bus.busy, 1'b0);
        check_output("abort_tx_ready", bus.tx_ready, 1'b1);
        saw_rxv = bus.rx_valid;
        repeat (3) begin @(negedge sys_clk); saw_rxv |= bus.rx_valid; end
        sync_rst_n = 1'b1;
        repeat (4) begin @(negedge sys_clk); saw_rxv |= bus.rx_valid; end
        check_output("abort_no_rx_valid", saw_rxv, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'hFF, 8'h00, 1'b1);
        check_output_xfer("after_reset", 1'b0);

        $display("[TB] divider extremes with gated enable");
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0, 2'd2, W'($urandom), W'($urandom), 1'b0);
        check_output_xfer("div0_gated", 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'd255, 2'd3, W'($urandom), W'($urandom), 1'b0);
        check_output_xfer("div255_gated", 1'b1);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom_range(0, 3)),
                           AW'($urandom), W'($urandom), W'($urandom), 1'b0);
            check_output_xfer("random", 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
